display_scan_ctrl: RTL and testbench

Time-multiplexing controller for the four-digit, common-anode 7-segment display on the BASYS board. It holds a four-digit BCD frame, sequences the active-low digit enables one digit at a time with a blanking gap between digits, and drives the shared active-low segment decoder. Upstream logic loads new frames through a load/ack handshake. Frames are swapped only at frame boundaries, so the display never tears.

---
 rtl/disp_pkg.sv | 26 ++
 rtl/bcd_seg_decode.sv | 17 +
 rtl/display_scan_ctrl.sv | 166 ++++++++++++++++
 tb/tb_display_scan_ctrl.sv | 211 +++++++++++++++++++++
 4 files changed

// File: rtl/disp_pkg.sv
// Shared types and constants for the 7-segment scan controller.
package disp_pkg;

    typedef enum logic {
        BLANK = 1'b0,
        SHOW  = 1'b1
    } state_t;

    localparam logic [6:0] SEG_OFF    = 7'h7F;
    localparam logic [3:0] ENABLE_OFF = 4'b1111;

    // Active-low segment patterns, seg[6]=a .. seg[0]=g, entry n is BCD digit n.
    localparam logic [9:0][6:0] SEG_TABLE = {
        7'b0000100,  // 9
        7'b0000000,  // 8
        7'b0001111,  // 7
        7'b0100000,  // 6
        7'b0100100,  // 5
        7'b1001100,  // 4
        7'b0000110,  // 3
        7'b0010010,  // 2
        7'b1001111,  // 1
        7'b0000001   // 0
    };

endpackage

// File: rtl/bcd_seg_decode.sv
// BCD to active-low 7-segment decode; non-decimal codes stay dark.
module bcd_seg_decode
    import disp_pkg::*;
(
    input  logic [3:0] bcd,
    output logic [6:0] seg
);

    // Table lookup for 0-9, everything else is blanked.
    always_comb begin
        seg = SEG_OFF;
        if (bcd <= 4'd9) begin
            seg = SEG_TABLE[bcd];
        end
    end

endmodule

// File: rtl/display_scan_ctrl.sv
// Four-digit multiplexed 7-segment scan controller with tear-free frame loading.
//
// state | meaning
// BLANK | all anodes off between digits, counts BLANK_CYCLES
// SHOW  | digit idx lit from the shadow frame, counts DWELL_CYCLES
module display_scan_ctrl
    import disp_pkg::*;
#(
    parameter int DWELL_CYCLES = 100000,
    parameter int BLANK_CYCLES = 1000
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        load,
    input  logic [15:0] digits_in,
    input  logic [3:0]  blank_mask,
    input  logic [3:0]  dp_mask,
    output logic        ack,
    output logic [3:0]  enable,
    output logic [6:0]  seg,
    output logic        dp
);

    localparam int MAX_CYCLES = (DWELL_CYCLES > BLANK_CYCLES) ? DWELL_CYCLES : BLANK_CYCLES;
    localparam int CNT_W      = $clog2(MAX_CYCLES);
    localparam logic [CNT_W-1:0] DWELL_LAST = CNT_W'(DWELL_CYCLES - 1);
    localparam logic [CNT_W-1:0] BLANK_LAST = CNT_W'(BLANK_CYCLES - 1);

    state_t           state_q, state_d;
    logic [1:0]       idx_q, idx_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             boundary;

    logic             pend_q, pend_d;
    logic [15:0]      pend_digits_q, pend_digits_d;
    logic [3:0]       pend_blank_q, pend_blank_d;
    logic [3:0]       pend_dp_q, pend_dp_d;

    logic [15:0]      shd_digits_q, shd_digits_d;
    logic [3:0]       shd_blank_q, shd_blank_d;
    logic [3:0]       shd_dp_q, shd_dp_d;

    logic             ack_q, ack_d;
    logic [3:0]       enable_q, enable_d;
    logic [6:0]       seg_q, seg_d;
    logic             dp_q, dp_d;

    logic [3:0]       digit_nib;
    logic [6:0]       dec_seg;

    // Scan sequencing: blank gap, then dwell on one digit, advancing idx on leaving SHOW.
    always_comb begin
        state_d  = state_q;
        idx_d    = idx_q;
        cnt_d    = cnt_q + CNT_W'(1);
        boundary = 1'b0;
        if (state_q == SHOW) begin
            if (cnt_q == DWELL_LAST) begin
                state_d  = BLANK;
                cnt_d    = '0;
                idx_d    = idx_q + 2'd1;
                boundary = (idx_q == 2'd3);
            end
        end else begin
            if (cnt_q == BLANK_LAST) begin
                state_d = SHOW;
                cnt_d   = '0;
            end
        end
    end

    // Pending/shadow handoff; a load on the boundary edge lands in pending only.
    always_comb begin
        pend_d        = pend_q;
        pend_digits_d = pend_digits_q;
        pend_blank_d  = pend_blank_q;
        pend_dp_d     = pend_dp_q;
        shd_digits_d  = shd_digits_q;
        shd_blank_d   = shd_blank_q;
        shd_dp_d      = shd_dp_q;
        ack_d         = 1'b0;
        if (boundary && pend_q) begin
            shd_digits_d = pend_digits_q;
            shd_blank_d  = pend_blank_q;
            shd_dp_d     = pend_dp_q;
            pend_d       = 1'b0;
            ack_d        = 1'b1;
        end
        if (load) begin
            pend_digits_d = digits_in;
            pend_blank_d  = blank_mask;
            pend_dp_d     = dp_mask;
            pend_d        = 1'b1;
        end
    end

    // Select the nibble for the digit about to be shown.
    always_comb begin
        digit_nib = shd_digits_d[3:0];
        case (idx_d)
            2'd0: digit_nib = shd_digits_d[3:0];
            2'd1: digit_nib = shd_digits_d[7:4];
            2'd2: digit_nib = shd_digits_d[11:8];
            2'd3: digit_nib = shd_digits_d[15:12];
            default: digit_nib = shd_digits_d[3:0];
        endcase
    end

    bcd_seg_decode u_dec (
        .bcd (digit_nib),
        .seg (dec_seg)
    );

    // Output values follow next-state so anodes and segments switch together with the FSM.
    always_comb begin
        enable_d = ENABLE_OFF;
        seg_d    = SEG_OFF;
        dp_d     = 1'b1;
        if (state_d == SHOW) begin
            enable_d[idx_d] = 1'b0;
            seg_d           = shd_blank_d[idx_d] ? SEG_OFF : dec_seg;
            dp_d            = ~shd_dp_d[idx_d];
        end
    end

    // State, frame and output registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q       <= BLANK;
            idx_q         <= 2'd0;
            cnt_q         <= '0;
            pend_q        <= 1'b0;
            pend_digits_q <= 16'h0000;
            pend_blank_q  <= 4'b0000;
            pend_dp_q     <= 4'b0000;
            shd_digits_q  <= 16'h0000;
            shd_blank_q   <= 4'b1111;
            shd_dp_q      <= 4'b0000;
            ack_q         <= 1'b0;
            enable_q      <= ENABLE_OFF;
            seg_q         <= SEG_OFF;
            dp_q          <= 1'b1;
        end else begin
            state_q       <= state_d;
            idx_q         <= idx_d;
            cnt_q         <= cnt_d;
            pend_q        <= pend_d;
            pend_digits_q <= pend_digits_d;
            pend_blank_q  <= pend_blank_d;
            pend_dp_q     <= pend_dp_d;
            shd_digits_q  <= shd_digits_d;
            shd_blank_q   <= shd_blank_d;
            shd_dp_q      <= shd_dp_d;
            ack_q         <= ack_d;
            enable_q      <= enable_d;
            seg_q         <= seg_d;
            dp_q          <= dp_d;
        end
    end

    assign ack    = ack_q;
    assign enable = enable_q;
    assign seg    = seg_q;
    assign dp     = dp_q;

endmodule

// File: tb/tb_display_scan_ctrl.sv
// Directed bench for display_scan_ctrl with DWELL=4, BLANK=1 (20-cycle frame).
module tb_display_scan_ctrl;

    logic        clk;
    logic        rst_n;
    logic        load;
    logic [15:0] digits_in;
    logic [3:0]  blank_mask;
    logic [3:0]  dp_mask;
    logic        ack;
    logic [3:0]  enable;
    logic [6:0]  seg;
    logic        dp;

    int tests_run;
    int tests_failed;
    int ph;

    display_scan_ctrl #(
        .DWELL_CYCLES (4),
        .BLANK_CYCLES (1)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .load       (load),
        .digits_in  (digits_in),
        .blank_mask (blank_mask),
        .dp_mask    (dp_mask),
        .ack        (ack),
        .enable     (enable),
        .seg        (seg),
        .dp         (dp)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    function automatic logic [6:0] bcd7(input logic [3:0] n);
        case (n)
            4'd0: bcd7 = 7'b0000001;
            4'd1: bcd7 = 7'b1001111;
            4'd2: bcd7 = 7'b0010010;
            4'd3: bcd7 = 7'b0000110;
            4'd4: bcd7 = 7'b1001100;
            4'd5: bcd7 = 7'b0100100;
            4'd6: bcd7 = 7'b0100000;
            4'd7: bcd7 = 7'b0001111;
            4'd8: bcd7 = 7'b0000000;
            4'd9: bcd7 = 7'b0000100;
            default: bcd7 = 7'h7F;
        endcase
    endfunction

    // ph = edges since reset release, mod frame length; sampling is 1 time unit after the edge.
    task automatic tick();
        @(posedge clk);
        ph = (ph + 1) % 20;
        #1;
    endtask

    task automatic advance_to(input int p);
        for (int n = 0; n < 25 && ph != p; n++) tick();
    endtask

    task automatic drive_load(input logic [15:0] d, input logic [3:0] bm, input logic [3:0] dm);
        load       = 1'b1;
        digits_in  = d;
        blank_mask = bm;
        dp_mask    = dm;
        tick();
        load       = 1'b0;
    endtask

    // Checks one full frame starting at ph==0 against the expected shadow contents.
    task automatic check_frame(input logic [15:0] dg, input logic [3:0] bm, input logic [3:0] dm,
                               input logic ack0, input string nm);
        logic [3:0] e_en;
        logic [6:0] e_seg;
        logic       e_dp;
        logic       e_ack;
        logic [3:0] nib;
        int         k;
        for (int j = 0; j < 20; j++) begin
            if (j > 0) tick();
            k = ph / 5;
            e_ack = (ph == 0) ? ack0 : 1'b0;
            if (ph % 5 == 0) begin
                e_en  = 4'b1111;
                e_seg = 7'h7F;
                e_dp  = 1'b1;
            end else begin
                e_en  = ~(4'b0001 << k);
                nib   = dg[k*4 +: 4];
                e_seg = (bm[k] || nib > 4'd9) ? 7'h7F : bcd7(nib);
                e_dp  = ~dm[k];
            end
            tests_run++;
            if (enable !== e_en || seg !== e_seg || dp !== e_dp || ack !== e_ack) begin
                tests_failed++;
                $display("FAIL %s ph=%0d: got en=%b seg=%b dp=%b ack=%b, expected en=%b seg=%b dp=%b ack=%b",
                         nm, ph, enable, seg, dp, ack, e_en, e_seg, e_dp, e_ack);
            end
        end
    endtask

    task automatic check_reset_outputs(input string nm);
        tests_run++;
        if (enable !== 4'b1111 || seg !== 7'h7F || dp !== 1'b1 || ack !== 1'b0) begin
            tests_failed++;
            $display("FAIL %s: got en=%b seg=%b dp=%b ack=%b, expected en=1111 seg=1111111 dp=1 ack=0",
                     nm, enable, seg, dp, ack);
        end
    endtask

    task automatic check_ack_low(input string nm);
        tests_run++;
        if (ack !== 1'b0) begin
            tests_failed++;
            $display("FAIL %s: got ack=%b, expected ack=0", nm, ack);
        end
    endtask

    task automatic test_reset();
        rst_n = 1'b1;
        #3 rst_n = 1'b0;
        #1;
        check_reset_outputs("reset_values");
        @(posedge clk);
        @(posedge clk);
        #1 rst_n = 1'b1;
        ph = 0;
        check_frame(16'h0000, 4'b1111, 4'b0000, 1'b0, "dark_frame");
        tick();
        check_frame(16'h0000, 4'b1111, 4'b0000, 1'b0, "dark_frame2");
    endtask

    task automatic test_load();
        tick();
        drive_load(16'h4321, 4'b0000, 4'b0010);
        advance_to(0);
        check_frame(16'h4321, 4'b0000, 4'b0010, 1'b1, "load_4321");
    endtask

    task automatic test_two_loads();
        advance_to(2);
        drive_load(16'h1111, 4'b0000, 4'b0000);
        advance_to(8);
        drive_load(16'h9876, 4'b0000, 4'b0000);
        advance_to(0);
        check_frame(16'h9876, 4'b0000, 4'b0000, 1'b1, "two_loads");
        tick();
        check_ack_low("two_loads_single_ack");
    endtask

    task automatic test_boundary_load();
        advance_to(19);
        drive_load(16'h5670, 4'b0000, 4'b1111);
        check_frame(16'h9876, 4'b0000, 4'b0000, 1'b0, "boundary_load_held");
        tick();
        check_frame(16'h5670, 4'b0000, 4'b1111, 1'b1, "boundary_load_next");
    endtask

    task automatic test_blank_digit();
        advance_to(3);
        drive_load(16'h765A, 4'b0100, 4'b0101);
        advance_to(0);
        check_frame(16'h765A, 4'b0100, 4'b0101, 1'b1, "blank_digits");
    endtask

    task automatic test_reset_mid();
        advance_to(1);
        drive_load(16'h2222, 4'b0000, 4'b0000);
        advance_to(12);
        tests_run++;
        if (enable !== 4'b1011) begin
            tests_failed++;
            $display("FAIL mid_digit2_lit: got en=%b, expected en=1011", enable);
        end
        rst_n = 1'b0;
        #1;
        check_reset_outputs("mid_reset_values");
        @(posedge clk);
        #1 rst_n = 1'b1;
        ph = 0;
        check_frame(16'h0000, 4'b1111, 4'b0000, 1'b0, "after_mid_reset");
        tick();
        check_frame(16'h0000, 4'b1111, 4'b0000, 1'b0, "after_mid_reset2");
    endtask

    initial begin
        tests_run    = 0;
        tests_failed = 0;
        ph           = 0;
        rst_n        = 1'b1;
        load         = 1'b0;
        digits_in    = 16'h0000;
        blank_mask   = 4'b0000;
        dp_mask      = 4'b0000;
        test_reset();
        test_load();
        test_two_loads();
        test_boundary_load();
        test_blank_digit();
        test_reset_mid();
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
